// File: rtl/nasti_lite_mem_writer.sv
// nasti_lite_mem_writer: NASTI-Lite AW/W/B slave that turns each lite beat into one memory write.
// Define NASTI_LITE_MEM_WRITER_DECODE_EN to answer DECERR (no write) for addresses at or above ADDR_LIMIT.
module nasti_lite_mem_writer #(
    parameter int     ID_WIDTH   = 1,
    parameter int     ADDR_WIDTH = 8,
    parameter int     DATA_WIDTH = 32,
    parameter int     USER_WIDTH = 1,
    parameter int     RESP_DEPTH = 2,
    parameter longint ADDR_LIMIT = longint'(1) << ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     lite_aw_id,
    input  logic [ADDR_WIDTH-1:0]   lite_aw_addr,
    input  logic [2:0]              lite_aw_prot,
    input  logic [3:0]              lite_aw_qos,
    input  logic [3:0]              lite_aw_region,
    input  logic [USER_WIDTH-1:0]   lite_aw_user,
    input  logic                    lite_aw_valid,
    output logic                    lite_aw_ready,
    input  logic [DATA_WIDTH-1:0]   lite_w_data,
    input  logic [DATA_WIDTH/8-1:0] lite_w_strb,
    input  logic [USER_WIDTH-1:0]   lite_w_user,
    input  logic                    lite_w_valid,
    output logic                    lite_w_ready,
    output logic [ID_WIDTH-1:0]     lite_b_id,
    output logic [1:0]              lite_b_resp,
    output logic [USER_WIDTH-1:0]   lite_b_user,
    output logic                    lite_b_valid,
    input  logic                    lite_b_ready,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_ready
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int PW = RESP_DEPTH > 1 ? $clog2(RESP_DEPTH) : 1;

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || USER_WIDTH < 1 || RESP_DEPTH < 1 ||
        (RESP_DEPTH & (RESP_DEPTH - 1)) != 0) begin : g_bad_params
        $fatal(1, "nasti_lite_mem_writer: illegal parameter combination");
    end

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                  state_q, state_d;
    logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ID_WIDTH-1:0]     aw_id_q, aw_id_d;
    logic [USER_WIDTH-1:0]   w_user_q, w_user_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [SW-1:0]           mem_wstrb_q, mem_wstrb_d;
    logic [PW:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ID_WIDTH-1:0]     bfifo_id [2**PW];
    logic [1:0]              bfifo_resp [2**PW];
    logic [USER_WIDTH-1:0]   bfifo_user [2**PW];
    logic                    aw_hs, w_hs, target, done, decerr, bfifo_empty, bfifo_full;
    logic [1:0]              resp;
    logic                    unused_ok;

`ifdef NASTI_LITE_MEM_WRITER_DECODE_EN
    logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
    assign decerr    = 64'(aw_addr_q) >= 64'(ADDR_LIMIT);
    assign aw_addr_d = aw_hs ? lite_aw_addr : aw_addr_q;
    assign unused_ok = ^{lite_aw_prot, lite_aw_qos, lite_aw_region, lite_aw_user};
`else
    assign decerr    = 1'b0;
    assign unused_ok = ^{lite_aw_prot, lite_aw_qos, lite_aw_region, lite_aw_user, 64'(ADDR_LIMIT)};
`endif

    always_comb begin
        aw_hs       = lite_aw_valid && !aw_held_q;
        w_hs        = lite_w_valid && !w_held_q;
        target      = (mem_wstrb_q != '0) && !decerr;
        done        = (state_q == ISSUE) && (!target || mem_ready);
        resp        = decerr ? 2'b11 : 2'b00;
        aw_held_d   = !done && (aw_held_q || aw_hs);
        w_held_d    = !done && (w_held_q || w_hs);
        aw_id_d     = aw_hs ? lite_aw_id : aw_id_q;
        mem_addr_d  = aw_hs ? (lite_aw_addr & ~ADDR_WIDTH'(SW - 1)) : mem_addr_q;
        mem_wdata_d = w_hs ? lite_w_data : mem_wdata_q;
        mem_wstrb_d = w_hs ? lite_w_strb : mem_wstrb_q;
        w_user_d    = w_hs ? lite_w_user : w_user_q;
        bfifo_empty = wr_ptr_q == rd_ptr_q;
        bfifo_full  = (wr_ptr_q - rd_ptr_q) == (PW + 1)'(RESP_DEPTH);
        wr_ptr_d    = wr_ptr_q + (PW + 1)'(done);
        rd_ptr_d    = rd_ptr_q + (PW + 1)'(!bfifo_empty && lite_b_ready);
        // Issue can start in the same cycle the second half of the beat is accepted.
        state_d     = done ? IDLE :
                      (state_q == IDLE && aw_held_d && w_held_d && !bfifo_full) ? ISSUE : state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            aw_id_q     <= '0;
            w_user_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
`ifdef NASTI_LITE_MEM_WRITER_DECODE_EN
            aw_addr_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            aw_id_q     <= aw_id_d;
            w_user_q    <= w_user_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
`ifdef NASTI_LITE_MEM_WRITER_DECODE_EN
            aw_addr_q   <= aw_addr_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (done) begin
            bfifo_id[wr_ptr_q[PW-1:0]]   <= aw_id_q;
            bfifo_resp[wr_ptr_q[PW-1:0]] <= resp;
            bfifo_user[wr_ptr_q[PW-1:0]] <= w_user_q;
        end
    end

    assign lite_aw_ready = !aw_held_q;
    assign lite_w_ready  = !w_held_q;
    assign lite_b_valid  = !bfifo_empty;
    assign lite_b_id     = bfifo_empty ? '0 : bfifo_id[rd_ptr_q[PW-1:0]];
    assign lite_b_resp   = bfifo_empty ? '0 : bfifo_resp[rd_ptr_q[PW-1:0]];
    assign lite_b_user   = bfifo_empty ? '0 : bfifo_user[rd_ptr_q[PW-1:0]];
    assign mem_we        = (state_q == ISSUE) && target;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wstrb     = mem_wstrb_q;
endmodule

// File: tb/tb_nasti_lite_mem_writer.sv
// tb_nasti_lite_mem_writer: directed and randomized checks of nasti_lite_mem_writer against a transaction-level model.
module tb_nasti_lite_mem_writer;
    logic        clk, rst;
    logic [1:0]  lite_aw_id;
    logic [7:0]  lite_aw_addr;
    logic [2:0]  lite_aw_prot;
    logic [3:0]  lite_aw_qos, lite_aw_region;
    logic        lite_aw_user, lite_aw_valid, lite_aw_ready;
    logic [31:0] lite_w_data;
    logic [3:0]  lite_w_strb;
    logic        lite_w_user, lite_w_valid, lite_w_ready;
    logic [1:0]  lite_b_id, lite_b_resp;
    logic        lite_b_user, lite_b_valid, lite_b_ready;
    logic        mem_we, mem_ready;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    nasti_lite_mem_writer #(
        .ID_WIDTH(2), .ADDR_WIDTH(8), .DATA_WIDTH(32), .USER_WIDTH(1), .RESP_DEPTH(2), .ADDR_LIMIT('h80)
    ) dut (
        .clk(clk), .rst(rst),
        .lite_aw_id(lite_aw_id), .lite_aw_addr(lite_aw_addr), .lite_aw_prot(lite_aw_prot),
        .lite_aw_qos(lite_aw_qos), .lite_aw_region(lite_aw_region), .lite_aw_user(lite_aw_user),
        .lite_aw_valid(lite_aw_valid), .lite_aw_ready(lite_aw_ready),
        .lite_w_data(lite_w_data), .lite_w_strb(lite_w_strb), .lite_w_user(lite_w_user),
        .lite_w_valid(lite_w_valid), .lite_w_ready(lite_w_ready),
        .lite_b_id(lite_b_id), .lite_b_resp(lite_b_resp), .lite_b_user(lite_b_user),
        .lite_b_valid(lite_b_valid), .lite_b_ready(lite_b_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready)
    );

    typedef struct packed { logic [7:0] addr; logic [1:0] id; } aw_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; logic user; } w_t;
    typedef struct packed { logic [7:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
    typedef struct packed { logic [1:0] id; logic [1:0] resp; logic user; } b_t;

    aw_t aw_q[$];
    w_t  w_q[$];
    wr_t exp_wr[$];
    b_t  exp_b[$];
    aw_t m_a;
    w_t  m_w;
    wr_t m_e, p_wr;
    b_t  m_b, p_b;
    logic m_dec, stall_prev, bhold_prev;
    int  checks = 0, errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: pair accepted AW/W beats in order, predict writes and responses.
    always @(negedge clk) begin
        if (rst) begin
            aw_q.delete(); w_q.delete(); exp_wr.delete(); exp_b.delete();
            stall_prev = 1'b0;
            bhold_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_we_held", mem_we, 1);
                chk("stall_stable", {mem_addr, mem_wdata, mem_wstrb}, p_wr);
            end
            if (bhold_prev) begin
                chk("b_valid_held", lite_b_valid, 1);
                chk("b_stable", {lite_b_id, lite_b_resp, lite_b_user}, p_b);
            end
            if (lite_aw_valid && lite_aw_ready) aw_q.push_back('{lite_aw_addr, lite_aw_id});
            if (lite_w_valid && lite_w_ready) w_q.push_back('{lite_w_data, lite_w_strb, lite_w_user});
            while (aw_q.size() > 0 && w_q.size() > 0) begin
                m_a = aw_q.pop_front();
                m_w = w_q.pop_front();
`ifdef NASTI_LITE_MEM_WRITER_DECODE_EN
                m_dec = m_a.addr >= 8'h80;
`else
                m_dec = 1'b0;
`endif
                if (m_w.strb != 4'h0 && !m_dec) exp_wr.push_back('{m_a.addr & 8'hFC, m_w.data, m_w.strb});
                exp_b.push_back('{m_a.id, m_dec ? 2'b11 : 2'b00, m_w.user});
            end
            if (mem_we && mem_ready) begin
                chk("mem_write_expected", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) begin
                    m_e = exp_wr.pop_front();
                    chk("mem_write", {mem_addr, mem_wdata, mem_wstrb}, m_e);
                end
            end
            if (lite_b_valid && lite_b_ready) begin
                chk("b_expected", exp_b.size() > 0, 1);
                if (exp_b.size() > 0) begin
                    m_b = exp_b.pop_front();
                    chk("b_resp_beat", {lite_b_id, lite_b_resp, lite_b_user}, m_b);
                end
            end
            stall_prev = mem_we && !mem_ready;
            p_wr = {mem_addr, mem_wdata, mem_wstrb};
            bhold_prev = lite_b_valid && !lite_b_ready;
            p_b = {lite_b_id, lite_b_resp, lite_b_user};
        end
    end

    task automatic step();
        logic awf, wf;
        @(negedge clk);
        awf = lite_aw_valid && lite_aw_ready;
        wf = lite_w_valid && lite_w_ready;
        @(posedge clk);
        #1;
        if (awf) lite_aw_valid = 1'b0;
        if (wf) lite_w_valid = 1'b0;
    endtask

    task automatic put_aw(input logic [1:0] id, input logic [7:0] addr);
        lite_aw_id = id;
        lite_aw_addr = addr;
        lite_aw_prot = 3'($urandom);
        lite_aw_qos = 4'($urandom);
        lite_aw_region = 4'($urandom);
        lite_aw_user = 1'($urandom);
        lite_aw_valid = 1'b1;
    endtask

    task automatic put_w(input logic [31:0] data, input logic [3:0] strb, input logic user);
        lite_w_data = data;
        lite_w_strb = strb;
        lite_w_user = user;
        lite_w_valid = 1'b1;
    endtask

    task automatic send(input logic [1:0] id, input logic [7:0] addr, input logic [31:0] data);
        put_aw(id, addr);
        put_w(data, 4'hF, 1'($urandom));
        for (int i = 0; i < 40 && (lite_aw_valid || lite_w_valid); i++) step();
        chk("send_accepted", {lite_aw_valid, lite_w_valid}, 0);
    endtask

    logic [1:0] got[$];
    int n_aw, n_w;

    initial begin
        rst = 1'b1;
        lite_aw_valid = 1'b0; lite_w_valid = 1'b0;
        lite_aw_id = '0; lite_aw_addr = '0; lite_aw_prot = '0; lite_aw_qos = '0;
        lite_aw_region = '0; lite_aw_user = 1'b0;
        lite_w_data = '0; lite_w_strb = '0; lite_w_user = 1'b0;
        lite_b_ready = 1'b1; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {lite_aw_ready, lite_w_ready}, 2'b11);
        chk("rst_valid_we", {lite_b_valid, mem_we}, 2'b00);
        chk("rst_b_fields", {lite_b_id, lite_b_resp, lite_b_user}, 0);
        chk("rst_mem_fields", {mem_addr, mem_wdata, mem_wstrb}, 0);
        rst = 1'b0;
        step();

        // Single write: handshake cycle 0, write cycle 1, response cycle 2.
        put_aw(2'd1, 8'h14);
        put_w(32'hDEADBEEF, 4'hF, 1'b0);
        chk("single_aw_ready0", lite_aw_ready, 1);
        step();
        chk("single_we1", mem_we, 1);
        chk("single_addr", mem_addr, 8'h14);
        chk("single_data", mem_wdata, 32'hDEADBEEF);
        chk("single_aw_busy", lite_aw_ready, 0);
        step();
        chk("single_bvalid2", lite_b_valid, 1);
        chk("single_b", {lite_b_id, lite_b_resp}, 4'b0100);
        chk("single_ready2", {lite_aw_ready, lite_w_ready, mem_we}, 3'b110);
        repeat (2) step();

        // W before AW.
        put_w(32'h1234_5678, 4'h3, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 3) put_aw(2'd2, 8'h23);
            chk("wfirst_w_ready", lite_w_ready, c == 5);
            chk("wfirst_we", mem_we, c == 4);
            if (c == 4) chk("wfirst_addr", mem_addr, 8'h20);
        end
        repeat (2) step();

        // Memory stall for five cycles.
        mem_ready = 1'b0;
        put_aw(2'd3, 8'h33);
        put_w(32'hCAFE_F00D, 4'hF, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 6) mem_ready = 1'b1;
            chk("stall_we", mem_we, c <= 6);
            if (c <= 6) chk("stall_addr", {mem_addr, mem_wdata}, {8'h30, 32'hCAFE_F00D});
            if (c <= 6) chk("stall_readies", {lite_aw_ready, lite_w_ready}, 2'b00);
            chk("stall_bvalid", lite_b_valid, c == 7);
        end
        repeat (2) step();

        // Zero strobe.
        put_aw(2'd2, 8'h40);
        put_w(32'hFFFF_FFFF, 4'h0, 1'b1);
        step();
        chk("zstrb_no_we", mem_we, 0);
        step();
        chk("zstrb_b", {lite_b_valid, lite_b_id, lite_b_resp, lite_b_user}, 6'b1_10_00_1);
        repeat (2) step();

`ifdef NASTI_LITE_MEM_WRITER_DECODE_EN
        put_aw(2'd1, 8'h84);
        put_w(32'h0BAD_0BAD, 4'hF, 1'b0);
        step();
        chk("dec_no_we", mem_we, 0);
        step();
        chk("dec_b", {lite_b_valid, lite_b_id, lite_b_resp}, 5'b1_01_11);
        repeat (2) step();
`endif

        // Reset while a write is stalled in ISSUE.
        mem_ready = 1'b0;
        put_aw(2'd1, 8'h50);
        put_w(32'h5555_AAAA, 4'hF, 1'b0);
        step();
        chk("rstmid_we_before", mem_we, 1);
        rst = 1'b1;
        step();
        chk("rstmid_after", {mem_we, lite_b_valid, lite_aw_ready, lite_w_ready}, 4'b0011);
        rst = 1'b0;
        mem_ready = 1'b1;
        step();

        // B backpressure with a two-entry response FIFO.
        lite_b_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(2'(i), 8'(8'h60 + 4 * i), $urandom);
        repeat (2) step();
        chk("bp_blocked", {lite_aw_ready, lite_w_ready}, 2'b00);
        chk("bp_head", {lite_b_valid, lite_b_id}, 3'b1_00);
        put_aw(2'd3, 8'h70);
        put_w($urandom, 4'hF, 1'b1);
        repeat (3) step();
        chk("bp_beat3_waiting", {lite_aw_valid, lite_w_valid}, 2'b11);
        lite_b_ready = 1'b1;
        for (int i = 0; i < 40 && got.size() < 4; i++) begin
            if (lite_b_valid) got.push_back(lite_b_id);
            step();
        end
        chk("bp_count", got.size(), 4);
        for (int k = 0; k < got.size(); k++) chk("bp_order", got[k], k);
        repeat (2) step();

        // Randomized traffic.
        n_aw = 0;
        n_w = 0;
        for (int cyc = 0; cyc < 20000 && (n_aw < 300 || n_w < 300 || lite_aw_valid || lite_w_valid); cyc++) begin
            mem_ready = $urandom_range(0, 3) != 0;
            lite_b_ready = $urandom_range(0, 2) != 0;
            if (!lite_aw_valid && n_aw < 300 && $urandom_range(0, 2) == 0) begin
                put_aw(2'($urandom), 8'($urandom));
                n_aw++;
            end
            if (!lite_w_valid && n_w < 300 && $urandom_range(0, 2) == 0) begin
                put_w($urandom, $urandom_range(0, 5) == 0 ? 4'h0 : 4'($urandom), 1'($urandom));
                n_w++;
            end
            step();
        end
        mem_ready = 1'b1;
        lite_b_ready = 1'b1;
        for (int i = 0; i < 200 && (exp_b.size() > 0 || lite_b_valid); i++) step();
        chk("drain_writes", exp_wr.size(), 0);
        chk("drain_resps", exp_b.size(), 0);
        chk("drain_idle", {lite_b_valid, lite_aw_ready, lite_w_ready}, 3'b011);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nasti_lite_mem_writer.md
# nasti_lite_mem_writer

NASTI-Lite write slave that terminates the lite AW/W/B channels produced by `nasti_lite_writer` and drives a simple synchronous memory/register write port. Each lite beat is held in single-entry AW and W holding registers. Once both are present, it is issued as one memory write. A response carrying the beat's id and user is then queued in a small B FIFO. It sits directly downstream of the NASTI-to-lite write converter, in front of peripheral register banks and scratch RAMs.

## Interface
- `ID_WIDTH`, 1: lite id width.
- `ADDR_WIDTH`, 8: byte address width.
- `DATA_WIDTH`, 32: lite data width; only 32 or 64 are legal, otherwise `$fatal` at elaboration.
- `USER_WIDTH`, 1: user field width, must be > 0.
- `RESP_DEPTH`, 2: B FIFO entries; power of two, ≥ 1.
- `ADDR_LIMIT`, 2**ADDR_WIDTH: first byte address outside the mapped window; used only with `NASTI_LITE_MEM_WRITER_DECODE_EN`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `lite_aw_id/addr/prot/qos/region/user` input ID_WIDTH/ADDR_WIDTH/3/4/4/USER_WIDTH: write address beat. `prot`, `qos` and `region` are accepted and ignored.
- `lite_aw_valid` input 1; `lite_aw_ready` output 1.
- `lite_w_data/strb/user` input DATA_WIDTH/DATA_WIDTH/8/USER_WIDTH: write data beat.
- `lite_w_valid` input 1; `lite_w_ready` output 1.
- `lite_b_id/resp/user` output ID_WIDTH/2/USER_WIDTH: write response.
- `lite_b_valid` output 1; `lite_b_ready` input 1.
- `mem_we` output 1: write request.
- `mem_addr` output ADDR_WIDTH: byte address with the low log2(DATA_WIDTH/8) bits forced to 0.
- `mem_wdata` output DATA_WIDTH; `mem_wstrb` output DATA_WIDTH/8.
- `mem_ready` input 1: the write completes in any cycle where `mem_we && mem_ready`.

## Operation
- **AW holding register:**
  - `aw_held` is set on an AW handshake and cleared on issue completion.
  - `lite_aw_ready = !aw_held`. There is no same-cycle bypass.
- **W holding register:** works identically to AW, with `w_held` and `lite_w_ready = !w_held`. AW and W may arrive in either order or in the same cycle.
- **Issue state machine, states IDLE and ISSUE:**
  - IDLE → ISSUE when `aw_held && w_held && !bfifo_full`.
  - In ISSUE, `mem_we` is asserted whenever the beat targets memory. The state machine leaves ISSUE on `mem_we && mem_ready`, or immediately (one cycle) when the beat does not target memory.
  - On leaving ISSUE, both holding registers are cleared, {aw_id, resp, w_user} is pushed into the B FIFO, and the state returns to IDLE.
- **Zero strobe:** a beat with `lite_w_strb == 0` does not assert `mem_we`. It still completes in one ISSUE cycle with OKAY.
- **Response codes:**
  - OKAY (2'b00) by default.
  - DECERR (2'b11) is produced only under the configuration macro; see Configuration.
- **B FIFO:**
  - `lite_b_valid = !bfifo_empty`; `lite_b_*` present the head entry.
  - The head pops on a `lite_b_valid && lite_b_ready` handshake.
  - Pointers wrap modulo RESP_DEPTH. Full and empty are distinguished by an extra pointer bit.
  - A push and a pop in the same cycle are both performed, and the occupancy is unchanged.
  - The full check for IDLE → ISSUE uses the registered full flag. A pop in the same cycle does not unblock issue until the next cycle.
- **Ordering:** responses are returned strictly in AW acceptance order.

## Timing
- **Reset values:**
  - `lite_aw_ready = 1`, `lite_w_ready = 1`.
  - `lite_b_valid = 0`, `mem_we = 0`.
  - `lite_b_id/resp/user = 0`, `mem_addr/wdata/wstrb = 0`.
  - FIFO empty, state IDLE.
- **Reset mid-operation:** held beats and queued responses are discarded, with no `mem_we` on the following cycle.
- **Latency:** AW and W handshakes in cycle 0 → ISSUE in cycle 1 with `mem_we = 1` (`mem_ready = 1`) → `lite_b_valid = 1` in cycle 2.
- **Readiness:** `lite_aw_ready` and `lite_w_ready` reassert in cycle 2.
- **Throughput:** sustained rate is one beat per 2 cycles.
- **Output stability:** `mem_addr`, `mem_wdata` and `mem_wstrb` are registered and stable for the whole ISSUE state. The same holds for `lite_b_*` while `lite_b_valid && !lite_b_ready`.
- **Memory stall:** if `mem_ready` stays low, `mem_we` stays high indefinitely and both ready outputs stay low.

## Configuration
- **`NASTI_LITE_MEM_WRITER_DECODE_EN` defined:**
  - A beat with `aw_addr >= ADDR_LIMIT` never asserts `mem_we`.
  - It completes in one ISSUE cycle with resp DECERR (2'b11).
- **Macro undefined:**
  - `ADDR_LIMIT` is ignored and every beat is written.
  - resp is constant OKAY, and the address compare logic is absent.

## Test plan
- **Single write:** AW addr 0x14 and W data 0xDEADBEEF, strb 0xF, id 1, in cycle 0 with `mem_ready = 1` → `mem_we` in cycle 1 with `mem_addr` 0x14. `lite_b_valid` in cycle 2 with id 1, resp 0.
- **W before AW:** W in cycle 0, AW in cycle 3 → `mem_we` in cycle 4 only. `lite_w_ready` is low in cycles 1–4.
- **Backpressure:** `lite_b_ready = 0` with RESP_DEPTH 2 and four beats sent, ids 0,1,2,3 → two responses queued, then `lite_aw_ready`/`lite_w_ready` low after the third beat is held. Raising `lite_b_ready` → ids return in order 0,1,2,3.
- **Memory stall:** `mem_ready` held low for 5 cycles → `mem_we` is high for 6 cycles with constant address and data. `lite_b_valid` follows one cycle after `mem_ready` rises.
- **Zero strobe and reset:**
  - Strobe 0x0 → no `mem_we`, B resp OKAY.
  - Reset asserted during ISSUE → the next cycle shows `mem_we = 0` and `lite_b_valid = 0`.
- **Decode (with `_DECODE_EN`, ADDR_LIMIT 0x80):** beat to addr 0x84 → no `mem_we`, B resp 2'b11.
